obi_spi_ram_ctrl: RTL
=====================

# obi_spi_ram_ctrl

OBI subordinate that maps a fixed address window onto an external serial SPI RAM (23LCxxx-style command set). It converts each accepted 32-bit OBI read or write into one complete SPI mode-0 transaction: command byte, address bytes, then four data bytes. It sits on the peripheral crossbar in place of the on-chip memory shim, with one outstanding request and a runtime-programmable SCK divider.

## Interface
- ObiCfg, obi_pkg::ObiDefaultConfig: OBI configuration. DataWidth is 32.
- obi_req_t, logic: OBI request struct.
- obi_rsp_t, logic: OBI response struct.
- BaseAddr, 32'h1000_0000: first byte address of the window.
- SpiRamMaxSize, 32'h800: window size in bytes; power of two.
- AddrBytes, 2: SPI address bytes sent per transaction; legal values 2 or 3.
- DivWidth, 8: width of clk_div_i.
- Ports:
  - clk_i  in  1  clock
  - rst_ni  in  1  reset, asynchronous, active-low
  - obi_req_i  in  obi_req_t  OBI request (req, a.addr, a.we, a.be, a.wdata, a.aid)
  - obi_rsp_o  out  obi_rsp_t  OBI response (gnt, rvalid, r.rdata, r.rid, r.err; r_optional tied '0)
  - clk_div_i  in  DivWidth  SCK half-period minus one, in clk_i cycles
  - spi_sck_o  out  1  SPI clock; reset 0
  - spi_cs_no  out  1  chip select, active low; reset 1
  - spi_mosi_o  out  1  serial data out; reset 0
  - spi_miso_i  in  1  serial data in
  - busy_o  out  1  high while not IDLE; reset 0

## Operation
- States: IDLE, SHIFT, HOLD, RESP, ERR.
- IDLE:
  - gnt = req, combinational.
  - On req&&gnt, latch addr, we, wdata, aid, and the divider value H = clk_div_i+1.
  - An access is an error if any of these hold: address outside [BaseAddr, BaseAddr+SpiRamMaxSize), addr[1:0]≠0, write with be≠4'hF, or write with macro off. Error goes to ERR; otherwise go to SHIFT.
- ERR: rvalid=1, err=1, rdata=0, rid=latched aid. No SPI activity. Return to IDLE.
- SHIFT:
  - spi_cs_no=0.
  - Frame is N = 8+8*AddrBytes+32 bits, MSB-first per byte:
    - command byte: 8'h03 for read, 8'h02 for write;
    - offset = addr-BaseAddr, truncated to 8*AddrBytes bits;
    - data bytes, sent or received as wdata[7:0] first, wdata[31:24] last.
  - Each bit period:
    - H cycles with sck low (MOSI valid from period start);
    - then H cycles with sck high. MISO is sampled on the cycle sck rises.
  - The next bit is driven when sck falls.
  - After bit N-1 falls, go to HOLD.
- Read data: the k-th received data byte goes to rdata[8k+7:8k]. During cmd/addr bits, MOSI carries the frame and MISO is ignored. During read data bits, MOSI=0.
- HOLD: H cycles, cs low, sck low. Then go to RESP.
- RESP: spi_cs_no=1, rvalid=1, err=0, rid=latched aid, rdata=read word (0 for writes). Return to IDLE.
- gnt=0 in every state except IDLE. rvalid is a single-cycle pulse; no rready back-pressure.
- clk_div_i changes mid-transaction have no effect.
- Reset mid-transaction: cs_no→1, sck→0, mosi→0 asynchronously. The transaction is dropped with no rvalid.

## Timing
- Grant cycle T0.
- SPI path: CS low from T1. rvalid at T0+1+2H·N+H. CS high in that same cycle.
- AddrBytes=2, div=0: N=56, rvalid at T0+114.
- Error path: rvalid at T0+1.
- Next gnt is possible from the cycle after rvalid.
- SCK frequency = f_clk/(2H). The maximum is f_clk/2.
- Divider counter is DivWidth bits. It reloads at every sck edge.

## Configuration
- OBI_SPI_RAM_WR_EN defined:
  - writes with be=4'hF perform SPI WRITE (8'h02) transactions;
  - writes with any other be get an err=1 response with no SPI activity (ERR path).
- Not defined:
  - every write gets an err=1 response with no SPI activity (ERR path);
  - the write datapath and the 8'h02 command are not synthesised;
  - reads are unchanged.

## Test plan
- Reset: with rst_ni low, cs_no=1, sck=0, mosi=0, busy=0, rvalid=0.
- Read, addr 0x1000_0010, div=0, aid=3, model MISO bytes 11,22,33,44:
  - MOSI frame 03 00 10;
  - rdata=0x4433_2211, rid=3, err=0;
  - rvalid at T0+114.
- Write, macro on, addr 0x1000_07FC, wdata 0xA1B2_C3D4, be=F, div=2:
  - MOSI frame 02 07 FC D4 C3 B2 A1;
  - SCK half-period 3 cycles;
  - rvalid at T0+340, err=0.
- Errors, no CS toggle, rvalid at T0+1, err=1:
  - addr 0x1000_0800 (out of range);
  - addr 0x1000_0002 (misaligned);
  - write with be=4'h3;
  - any write with macro off.
- Back-to-back: a second req held from the rvalid cycle is not granted until the following cycle. clk_div_i changed mid-transaction keeps the original SCK rate.
- Async reset asserted at bit 20 of a read: cs_no=1 immediately, no rvalid. After reset release, a new read completes correctly.

Source files
------------

// File: rtl/obi_spi_ram_ctrl.sv
// obi_spi_ram_ctrl: OBI subordinate mapping a fixed address window onto a
// 23LCxxx-style serial SPI RAM (mode 0, one outstanding request).
// Optional feature macro: OBI_SPI_RAM_WR_EN (enables SPI WRITE transactions).

package obi_spi_ram_ctrl_pkg;
    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 4;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: ObiAddrWidth,
        DataWidth: ObiDataWidth,
        IdWidth:   ObiIdWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
        logic                    r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module obi_spi_ram_ctrl #(
    parameter obi_spi_ram_ctrl_pkg::obi_cfg_t ObiCfg = obi_spi_ram_ctrl_pkg::ObiDefaultConfig,
    parameter type         obi_req_t     = obi_spi_ram_ctrl_pkg::obi_req_t,
    parameter type         obi_rsp_t     = obi_spi_ram_ctrl_pkg::obi_rsp_t,
    parameter logic [31:0] BaseAddr      = 32'h1000_0000,
    parameter logic [31:0] SpiRamMaxSize = 32'h800,
    parameter int unsigned AddrBytes     = 2,
    parameter int unsigned DivWidth      = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  obi_req_t            obi_req_i,
    output obi_rsp_t            obi_rsp_o,
    input  logic [DivWidth-1:0] clk_div_i,
    output logic                spi_sck_o,
    output logic                spi_cs_no,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i,
    output logic                busy_o
);
    localparam int unsigned DataWidth = ObiCfg.DataWidth;
    localparam int unsigned IdWidth   = ObiCfg.IdWidth;
    localparam int unsigned OffWidth  = 8 * AddrBytes;
    localparam int unsigned FrameBits = 8 + OffWidth + 32;
    localparam int unsigned BitWidth  = $clog2(FrameBits);

    typedef enum logic [2:0] {IDLE, SHIFT, HOLD, RESP, ERR} state_e;

    state_e                 state_q, state_d;
    logic [DivWidth-1:0]    div_q, cnt_q;
    logic [BitWidth-1:0]    bit_q;
    logic [FrameBits-1:0]   tx_q, frame_c;
    logic [DataWidth-1:0]   rx_q, rdata_q;
    logic [IdWidth-1:0]     aid_q;
    logic                   we_q, sck_q, cs_n_q, busy_q, rvalid_q, err_q;
    logic [31:0]            offset_c;
    logic                   in_range_c, acc_err_c, tick_c, gnt_c;

    // Window decode on the incoming request
    assign offset_c   = obi_req_i.a.addr - BaseAddr;
    assign in_range_c = (obi_req_i.a.addr >= BaseAddr) && (offset_c < SpiRamMaxSize);
    assign tick_c     = (cnt_q == '0);

`ifdef OBI_SPI_RAM_WR_EN
    // Full-word writes become SPI WRITE frames; data bytes go out LSB byte first
    assign acc_err_c = !in_range_c || (obi_req_i.a.addr[1:0] != 2'b00)
                       || (obi_req_i.a.we && (obi_req_i.a.be != 4'hF));
    assign frame_c   = obi_req_i.a.we
                       ? {8'h02, OffWidth'(offset_c),
                          obi_req_i.a.wdata[7:0],   obi_req_i.a.wdata[15:8],
                          obi_req_i.a.wdata[23:16], obi_req_i.a.wdata[31:24]}
                       : {8'h03, OffWidth'(offset_c), 32'h0};
`else
    // Read-only build: every write is refused
    assign acc_err_c = !in_range_c || (obi_req_i.a.addr[1:0] != 2'b00) || obi_req_i.a.we;
    assign frame_c   = {8'h03, OffWidth'(offset_c), 32'h0};
    logic unused_wr;
    assign unused_wr = ^{obi_req_i.a.wdata, obi_req_i.a.be};
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and combinational grant
    always_comb begin
        state_d = state_q;
        gnt_c   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_c = obi_req_i.req;
                if (obi_req_i.req) state_d = acc_err_c ? ERR : SHIFT;
            end
            SHIFT: if (tick_c && sck_q && (bit_q == BitWidth'(FrameBits - 1))) state_d = HOLD;
            HOLD:  if (tick_c) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // SCK divider, frame shifter, capture and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            aid_q    <= '0;
            we_q     <= 1'b0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= (state_d != IDLE);
            cs_n_q   <= !(state_d inside {SHIFT, HOLD});
            case (state_q)
                IDLE: if (obi_req_i.req) begin
                    we_q  <= obi_req_i.a.we;
                    aid_q <= obi_req_i.a.aid;
                    div_q <= clk_div_i;
                    cnt_q <= clk_div_i;
                    bit_q <= '0;
                    sck_q <= 1'b0;
                    if (acc_err_c) begin
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        tx_q <= frame_c;
                    end
                end
                SHIFT: begin
                    if (!tick_c) begin
                        cnt_q <= cnt_q - DivWidth'(1);
                    end else begin
                        cnt_q <= div_q;
                        sck_q <= !sck_q;
                        if (!sck_q) begin
                            rx_q <= {rx_q[DataWidth-2:0], spi_miso_i};
                        end else begin
                            tx_q  <= {tx_q[FrameBits-2:0], 1'b0};
                            bit_q <= bit_q + BitWidth'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!tick_c) begin
                        cnt_q <= cnt_q - DivWidth'(1);
                    end else begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= we_q ? '0 : {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Output mapping
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = gnt_c;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = aid_q;
        obi_rsp_o.r.err   = err_q;
    end

    assign spi_sck_o  = sck_q;
    assign spi_cs_no  = cs_n_q;
    assign spi_mosi_o = tx_q[FrameBits-1];
    assign busy_o     = busy_q;

endmodule
